// File: rtl/mem_ram_256x8.sv
// ---------------------------------------------------------------------------
// mem_ram_256x8
//   256 x 8 byte-addressed RAM with a request/complete handshake and a
//   programmable number of wait states.  Byte, halfword and word accesses are
//   stored big-endian: byte 0 of a word (bits 31:24) lives at the lowest
//   address.  Only naturally aligned accesses are legal, so no access ever
//   wraps past address 255.
//
// Parameters
//   WAIT_CYCLES  wait states inserted before each access completes (0..15)
//
// Ports
//   Clk       in   1   clock, rising edge
//   Reset     in   1   synchronous, active-high; does not clear the array
//   MOV       in   1   operation request, held high until MOC is seen
//   RW        in   1   1 = read, 0 = write
//   Datatype  in   2   00 byte, 01 halfword, 10 word, 11 illegal
//   Address   in   8   byte address
//   DataIn    in  32   write data, right-justified for byte/halfword
//   DataOut   out 32   read data (0 on a rejected access, held on a write)
//   MOC       out  1   operation complete, high in DONE
//   Error     out  1   completed operation was rejected
// ---------------------------------------------------------------------------
module mem_ram_256x8 #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MOV,
  input  logic        RW,
  input  logic [1:0]  Datatype,
  input  logic [7:0]  Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MOC,
  output logic        Error
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;

  // Request copies captured at acceptance; BUSY works only from these.
  logic [7:0]  addr_p0;
  logic        rw_p0;
  logic [1:0]  dtype_p0;
  logic [31:0] din_p0;

  // Zero-filled at time 0; Reset deliberately leaves the contents alone.
  logic [7:0]  mem [0:255] = '{default: 8'h00};

  logic        accept;
  logic        complete;
  logic        legal;
  logic        mem_we;
  logic [7:0]  addr1, addr2, addr3;
  logic [31:0] rd_word;

  function automatic logic is_legal(input logic [1:0] dt, input logic [7:0] a);
    logic ok;
    case (dt)
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~a[0];
      2'b10:   ok = (a[1:0] == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] assemble(input logic [1:0] dt,
                                           input logic [7:0] b0,
                                           input logic [7:0] b1,
                                           input logic [7:0] b2,
                                           input logic [7:0] b3);
    logic [31:0] w;
    case (dt)
      2'b00:   w = {24'h0, b0};
      2'b01:   w = {16'h0, b0, b1};
      2'b10:   w = {b0, b1, b2, b3};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  // Neighbouring byte addresses; the 8-bit wrap only occurs for misaligned
  // requests, which are rejected before these are ever used.
  assign addr1    = addr_p0 + 8'd1;
  assign addr2    = addr_p0 + 8'd2;
  assign addr3    = addr_p0 + 8'd3;

  assign accept   = (state == IDLE) && MOV;
  assign complete = (state == BUSY) && (cnt == 4'd0);
  assign legal    = is_legal(dtype_p0, addr_p0);
  // The only write point: the BUSY->DONE edge, suppressed by a reset abort.
  assign mem_we   = complete && legal && !rw_p0 && !Reset;
  assign rd_word  = assemble(dtype_p0, mem[addr_p0], mem[addr1],
                             mem[addr2], mem[addr3]);

  // ---- request capture ----
  always_ff @(posedge Clk) begin
    if (accept) begin
      addr_p0  <= Address;
      rw_p0    <= RW;
      dtype_p0 <= Datatype;
      din_p0   <= DataIn;
    end
  end

  // ---- array write ----
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      case (dtype_p0)
        2'b00: mem[addr_p0] <= din_p0[7:0];
        2'b01: begin
          mem[addr_p0] <= din_p0[15:8];
          mem[addr1]   <= din_p0[7:0];
        end
        2'b10: begin
          mem[addr_p0] <= din_p0[31:24];
          mem[addr1]   <= din_p0[23:16];
          mem[addr2]   <= din_p0[15:8];
          mem[addr3]   <= din_p0[7:0];
        end
        default: ;
      endcase
    end
  end

  // ---- control FSM and registered outputs ----
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      MOC     <= 1'b0;
      Error   <= 1'b0;
      DataOut <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (MOV) begin
            cnt   <= WAIT_LD;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= DONE;
            MOC   <= 1'b1;
            Error <= ~legal;
            // A legal write keeps the previous read data on DataOut.
            if (!legal)
              DataOut <= 32'h0;
            else if (rw_p0)
              DataOut <= rd_word;
          end
        end
        DONE: begin
          // Stay here while the request is held so it cannot re-trigger.
          if (!MOV) begin
            state <= IDLE;
            MOC   <= 1'b0;
            Error <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ram_256x8.sv
module tb_mem_ram_256x8;

  localparam int W0 = 2;

  logic        clk;
  logic        Reset;
  logic        MOV0, MOV1;
  logic        RW;
  logic [1:0]  Datatype;
  logic [7:0]  Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut0, DataOut1;
  logic        MOC0, MOC1;
  logic        Error0, Error1;

  int total = 0;
  int bad   = 0;

  mem_ram_256x8 #(.WAIT_CYCLES(W0)) u0 (
    .Clk(clk), .Reset(Reset), .MOV(MOV0), .RW(RW), .Datatype(Datatype),
    .Address(Address), .DataIn(DataIn), .DataOut(DataOut0), .MOC(MOC0),
    .Error(Error0)
  );

  mem_ram_256x8 #(.WAIT_CYCLES(0)) u1 (
    .Clk(clk), .Reset(Reset), .MOV(MOV1), .RW(RW), .Datatype(Datatype),
    .Address(Address), .DataIn(DataIn), .DataOut(DataOut1), .MOC(MOC1),
    .Error(Error1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level reference for u0 ----------------
  // A request accepted at one edge completes exactly W0+1 edges later; the
  // result is computed from the byte array with big-endian byte order.
  logic [7:0]  refmem [256] = '{default: 8'h00};
  logic        m_valid = 1'b0;
  logic        m_busy  = 1'b0;
  logic        m_done  = 1'b0;
  int          m_rem   = 0;
  logic        m_rw;
  logic [1:0]  m_dt;
  logic [7:0]  m_a;
  logic [31:0] m_din;
  logic        exp_moc = 1'b0;
  logic        exp_err = 1'b0;
  logic [31:0] exp_dout = 32'h0;
  int          m_nb;
  logic        m_ok;
  logic [31:0] m_acc;

  always @(posedge clk) begin
    if (Reset) begin
      m_valid  = 1'b1;
      m_busy   = 1'b0;
      m_done   = 1'b0;
      exp_moc  = 1'b0;
      exp_err  = 1'b0;
      exp_dout = 32'h0;
    end else if (m_done) begin
      if (!MOV0) begin
        m_done  = 1'b0;
        exp_moc = 1'b0;
        exp_err = 1'b0;
      end
    end else if (m_busy) begin
      m_rem--;
      if (m_rem == 0) begin
        m_nb = (m_dt == 2'd0) ? 1 : (m_dt == 2'd1) ? 2 : (m_dt == 2'd2) ? 4 : 0;
        m_ok = 1'b0;
        if (m_nb != 0) m_ok = ((int'(m_a) % m_nb) == 0);
        if (!m_ok) begin
          exp_dout = 32'h0;
          exp_err  = 1'b1;
        end else begin
          exp_err = 1'b0;
          if (m_rw) begin
            m_acc = 32'h0;
            for (int i = 0; i < m_nb; i++)
              m_acc = (m_acc << 8) | 32'(refmem[int'(m_a) + i]);
            exp_dout = m_acc;
          end else begin
            for (int i = 0; i < m_nb; i++)
              refmem[int'(m_a) + i] = m_din[8*(m_nb-1-i) +: 8];
          end
        end
        exp_moc = 1'b1;
        m_done  = 1'b1;
        m_busy  = 1'b0;
      end
    end else if (MOV0) begin
      m_rw   = RW;
      m_dt   = Datatype;
      m_a    = Address;
      m_din  = DataIn;
      m_busy = 1'b1;
      m_rem  = W0 + 1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("u0_moc",  32'(MOC0),   32'(exp_moc));
      check("u0_err",  32'(Error0), 32'(exp_err));
      check("u0_dout", DataOut0,    exp_dout);
    end
  end

  // ---------------- stimulus ----------------
  task automatic req0(input logic rw, input logic [1:0] dt, input logic [7:0] a,
                      input logic [31:0] din, output logic [31:0] dout,
                      output logic err, output int lat);
    @(negedge clk);
    RW = rw; Datatype = dt; Address = a; DataIn = din; MOV0 = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!MOC0 && lat < 30);
    if (!MOC0) check("u0_moc_timeout", 32'(MOC0), 32'd1);
    dout = DataOut0;
    err  = Error0;
    MOV0 = 1'b0;
    @(negedge clk);
  endtask

  logic [31:0] d;
  logic        e;
  int          lat;

  initial begin
    Reset = 1'b1; MOV0 = 1'b0; MOV1 = 1'b0;
    RW = 1'b0; Datatype = 2'd0; Address = 8'd0; DataIn = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_moc0",  32'(MOC0),   32'd0);
    check("rst_err0",  32'(Error0), 32'd0);
    check("rst_dout0", DataOut0,    32'h0);
    check("rst_moc1",  32'(MOC1),   32'd0);
    check("rst_err1",  32'(Error1), 32'd0);
    check("rst_dout1", DataOut1,    32'h0);
    Reset = 1'b0;

    // word write then reads at various widths
    req0(1'b0, 2'd2, 8'd8, 32'hDEADBEEF, d, e, lat);
    check("wr8_lat", 32'(lat), 32'd4);
    check("wr8_err", 32'(e), 32'd0);
    req0(1'b1, 2'd2, 8'd8, 32'h0, d, e, lat);
    check("rdw8", d, 32'hDEADBEEF);
    check("rdw8_err", 32'(e), 32'd0);
    req0(1'b1, 2'd0, 8'd8, 32'h0, d, e, lat);
    check("rdb8", d, 32'h000000DE);
    req0(1'b1, 2'd0, 8'd11, 32'h0, d, e, lat);
    check("rdb11", d, 32'h000000EF);
    req0(1'b1, 2'd0, 8'd9, 32'h0, d, e, lat);
    check("rdb9", d, 32'h000000AD);
    req0(1'b1, 2'd1, 8'd10, 32'h0, d, e, lat);
    check("rdh10", d, 32'h0000BEEF);

    // sub-word writes; a write keeps the previous DataOut
    req0(1'b0, 2'd0, 8'd9, 32'hFFFFFF77, d, e, lat);
    check("wrb9_hold", d, 32'h0000BEEF);
    req0(1'b1, 2'd2, 8'd8, 32'h0, d, e, lat);
    check("rdw8_b", d, 32'hDE77BEEF);
    req0(1'b0, 2'd1, 8'd12, 32'hAAAA1234, d, e, lat);
    req0(1'b1, 2'd2, 8'd12, 32'h0, d, e, lat);
    check("rdw12", d, 32'h12340000);

    // rejected accesses
    req0(1'b0, 2'd2, 8'd4, 32'hA1B2C3D4, d, e, lat);
    req0(1'b0, 2'd2, 8'd6, 32'h11223344, d, e, lat);
    check("mis_w6_err", 32'(e), 32'd1);
    check("mis_w6_dout", d, 32'h0);
    check("mis_w6_lat", 32'(lat), 32'd4);
    req0(1'b1, 2'd2, 8'd4, 32'h0, d, e, lat);
    check("rdw4_intact", d, 32'hA1B2C3D4);
    req0(1'b1, 2'd1, 8'd3, 32'h0, d, e, lat);
    check("mis_h3_err", 32'(e), 32'd1);
    check("mis_h3_dout", d, 32'h0);
    req0(1'b1, 2'd3, 8'd0, 32'h0, d, e, lat);
    check("dt11_err", 32'(e), 32'd1);

    // top of the array
    req0(1'b0, 2'd2, 8'd252, 32'h01020304, d, e, lat);
    check("wr252_err", 32'(e), 32'd0);
    req0(1'b1, 2'd0, 8'd255, 32'h0, d, e, lat);
    check("rdb255", d, 32'h00000004);
    req0(1'b1, 2'd2, 8'd253, 32'h0, d, e, lat);
    check("mis_w253_err", 32'(e), 32'd1);
    req0(1'b1, 2'd2, 8'd252, 32'h0, d, e, lat);
    check("rdw252", d, 32'h01020304);

    // latency and hold behaviour with MOV kept high through DONE
    @(negedge clk);
    RW = 1'b1; Datatype = 2'd2; Address = 8'd8; MOV0 = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!MOC0 && lat < 30);
    check("lat_hold", 32'(lat), 32'd4);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_moc", 32'(MOC0), 32'd1);
      check("hold_dout", DataOut0, 32'hDE77BEEF);
    end
    MOV0 = 1'b0;
    @(negedge clk);
    check("release_moc", 32'(MOC0), 32'd0);

    // reset in the first BUSY cycle aborts the write
    @(negedge clk);
    RW = 1'b0; Datatype = 2'd2; Address = 8'd16; DataIn = 32'hCAFEF00D;
    MOV0 = 1'b1;
    @(negedge clk);
    Reset = 1'b1; MOV0 = 1'b0;
    @(negedge clk);
    Reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("abort_moc", 32'(MOC0), 32'd0);
    end
    req0(1'b1, 2'd2, 8'd16, 32'h0, d, e, lat);
    check("abort_rd16", d, 32'h0);
    check("abort_lat", 32'(lat), 32'd4);

    // zero wait states on u1, back-to-back handling
    @(negedge clk);
    RW = 1'b0; Datatype = 2'd2; Address = 8'd0; DataIn = 32'h12345678;
    MOV1 = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!MOC1 && lat < 30);
    check("u1_wr_lat", 32'(lat), 32'd2);
    check("u1_wr_err", 32'(Error1), 32'd0);
    RW = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("u1_hold_moc", 32'(MOC1), 32'd1);
      check("u1_hold_dout", DataOut1, 32'h0);
    end
    MOV1 = 1'b0;
    @(negedge clk);
    check("u1_rel_moc", 32'(MOC1), 32'd0);
    MOV1 = 1'b1;
    @(negedge clk);
    check("u1_busy_moc", 32'(MOC1), 32'd0);
    @(negedge clk);
    check("u1_rd_moc", 32'(MOC1), 32'd1);
    check("u1_rd_dout", DataOut1, 32'h12345678);
    check("u1_rd_err", 32'(Error1), 32'd0);
    MOV1 = 1'b0;
    @(negedge clk);
    check("u1_end_moc", 32'(MOC1), 32'd0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_ram_256x8.md
MEM_RAM_256X8 -- requirements
Module: mem_ram_256x8

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, meaning wait-state count inserted before each access completes; legal range 0..15.
REQ-002 Clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 MOV  input  1  memory operation valid; a level-held request from the control unit.
REQ-005 RW  input  1  1 = read, 0 = write.
REQ-006 Datatype  input  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-007 Address  input  8  byte address into a 256 x 8 array.
REQ-008 DataIn  input  32  write data, driven from the MDR output; byte/halfword data is right-justified.
REQ-009 DataOut  output  32  read data, consumed by the MDR input.
REQ-010 MOC  output  1  memory operation complete.
REQ-011 Error  output  1  the completed operation was rejected.

Function
REQ-012 The FSM SHALL have three states, IDLE, BUSY and DONE, plus a 4-bit wait counter.
REQ-013 In IDLE with MOV=1 at the edge, the block SHALL latch Address, RW, Datatype and DataIn, load the counter with WAIT_CYCLES, and enter BUSY.
REQ-014 In BUSY, inputs other than Reset SHALL be ignored; all inputs are taken from the latched copies.
REQ-015 In BUSY with counter≠0, the counter SHALL decrement; with counter=0, the access SHALL be performed and the FSM SHALL enter DONE on that edge.
REQ-016 Latency: MOV sampled at edge n SHALL produce MOC=1 after edge n+WAIT_CYCLES+1 (WAIT_CYCLES=0 gives MOC after edge n+1).
REQ-017 In DONE, MOC=1, and DataOut and Error SHALL stay stable while MOV=1.
REQ-018 In DONE with MOV=0 at the edge, the FSM SHALL return to IDLE with MOC=0; a new request needs MOV low for at least one sampled edge.
REQ-019 Storage SHALL be big-endian: the word at A holds byte 0 = bits 31:24 at A, and byte 3 = bits 7:0 at A+3.
REQ-020 Byte read SHALL give DataOut = {24'h0, mem[A]}.
REQ-021 Halfword read SHALL give DataOut = {16'h0, mem[A], mem[A+1]}.
REQ-022 Word read SHALL give DataOut = {mem[A], mem[A+1], mem[A+2], mem[A+3]}.
REQ-023 Byte write SHALL store DataIn[7:0]; halfword write SHALL store DataIn[15:0]; word write SHALL store all 32 bits, in big-endian order.
REQ-024 A write SHALL leave DataOut unchanged from its previous value.
REQ-025 Misalignment (halfword with A[0]=1, or word with A[1:0]≠00) or Datatype=11 SHALL cause: no memory change, DataOut=0, Error=1, MOC=1 with normal latency.
REQ-026 Error SHALL clear on the DONE→IDLE transition.
REQ-027 Because only aligned accesses are legal, no access SHALL wrap past address 255; a word at 252 is legal and a word at 253 is an error.
REQ-028 A memory write SHALL occur only on the BUSY→DONE edge, exactly once per request.

Reset
REQ-029 With Reset=1 at an edge: FSM→IDLE, counter=0, MOC=0, Error=0, DataOut=32'h0; Reset SHALL take priority over MOV.
REQ-030 Reset during BUSY SHALL abort the operation with no memory write.
REQ-031 Reset SHALL NOT clear the memory array; simulation initializes the array to all zeros at time 0.
REQ-032 After Reset deasserts, a request SHALL be accepted on the first edge with MOV=1.

Verification
REQ-033 Word write then read: write 32'hDEADBEEF to address 8, then read a word from 8 -> DataOut=32'hDEADBEEF, mem[8]=DE, mem[11]=EF, Error=0.
REQ-034 Sub-word reads after the REQ-033 write: byte read at 9 -> 32'h000000AD; halfword read at 10 -> 32'h0000BEEF.
REQ-035 Latency: with WAIT_CYCLES=2, MOV rises before edge 5 -> MOC first high after edge 8; MOV held 3 more cycles -> MOC stays 1; MOV low -> MOC=0 after the next edge.
REQ-036 Misaligned access: word write 32'h11223344 to address 6 -> MOC=1, Error=1, mem[4..7] unchanged; halfword read at 3 -> DataOut=0, Error=1.
REQ-037 Reset abort: start a word write of 32'hCAFEF00D to address 16, pulse Reset in the first BUSY cycle -> MOC never asserts and a later read at 16 returns 32'h0.
REQ-038 Back-to-back requests and WAIT_CYCLES=0: with MOV held high through DONE, no second operation starts; drop MOV for one edge, re-raise it for a read -> MOC after exactly one edge.
